// File: rtl/xor_op64.sv
// -----------------------------------------------------------------------------
// xor_op64 -- bitwise XOR datapath unit for the ALU
//
// Computes a ^ b two ways:
//   * a zero-latency combinational result for the ALU result mux
//   * a registered copy with a valid flag, a zero flag and a Hamming-distance
//     count (popcount of a ^ b) for the compare/flag logic
//
// Parameters
//   WIDTH      operand/result width in bits (1..64)
//   CNT_W      Hamming-count width, must equal $clog2(WIDTH+1)
//
// Ports
//   clk        in   1      rising-edge clock for the registered path
//   rst_n      in   1      asynchronous, active-low reset
//   a          in   WIDTH  operand A
//   b          in   WIDTH  operand B
//   result     out  WIDTH  combinational a ^ b (no clock/reset dependence)
//   in_valid   in   1      capture a ^ b into the registered path this cycle
//   out_valid  out  1      registered outputs hold a capture from last cycle
//   result_q   out  WIDTH  registered a ^ b
//   zero_q     out  1      registered (a == b)
//   hamming_q  out  CNT_W  registered count of 1 bits in a ^ b (0..WIDTH)
// -----------------------------------------------------------------------------
module xor_op64 #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  input  logic             in_valid,
  output logic             out_valid,
  output logic [WIDTH-1:0] result_q,
  output logic             zero_q,
  output logic [CNT_W-1:0] hamming_q
);

  // Popcount tree is built over the next power of two at or above WIDTH;
  // the pad bits are tied to zero so they never contribute to the count.
  localparam int P      = (WIDTH <= 1) ? 1 : (1 << $clog2(WIDTH));
  localparam int LEVELS = $clog2(P);

  generate
    if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
      $error("xor_op64: WIDTH must be in 1..64");
    end
    if (CNT_W != $clog2(WIDTH + 1)) begin : g_bad_cnt_w
      $error("xor_op64: CNT_W must equal $clog2(WIDTH+1)");
    end
  endgenerate

  // Balanced pairwise adder tree, reduced in place: at each level node n
  // becomes the sum of nodes 2n and 2n+1 of the previous level. Node n only
  // reads indices >= n, so the in-place update never consumes a value that
  // was already overwritten on the same level. Depth is log2(P) adders,
  // which keeps the path well inside one cycle.
  function automatic logic [CNT_W-1:0] f_popcount(input logic [P-1:0] v);
    logic [CNT_W-1:0] s [P];
    for (int n = 0; n < P; n++) begin
      s[n] = CNT_W'(v[n]);
    end
    for (int l = 0; l < LEVELS; l++) begin
      for (int n = 0; n < (P >> (l + 1)); n++) begin
        s[n] = s[2*n] + s[2*n+1];
      end
    end
    return s[0];
  endfunction

  logic [WIDTH-1:0] w_diff;
  logic [P-1:0]     w_diff_pad;
  logic [CNT_W-1:0] w_hamming;
  logic             w_zero;

  // NOTE: every combinational output is given a value on every path through
  // the block (here unconditionally), so no latch can be inferred.
  always_comb begin
    w_diff     = a ^ b;
    w_diff_pad = P'(w_diff);
    w_zero     = ~|w_diff;
    w_hamming  = f_popcount(w_diff_pad);
  end

  // Combinational result: deliberately independent of clk and rst_n.
  assign result = w_diff;

  logic             r_valid;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic [CNT_W-1:0] r_hamming;

  // Valid follows in_valid every cycle; the payload registers load only on
  // a capture and otherwise hold, so a consumer can still read the last
  // result after out_valid drops. Reset clears everything at once and
  // discards any capture that was in flight.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs as they were before this edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid   <= 1'b0;
      r_result  <= '0;
      r_zero    <= 1'b0;
      r_hamming <= '0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_result  <= w_diff;
        r_zero    <= w_zero;
        r_hamming <= w_hamming;
      end
    end
  end

  assign out_valid = r_valid;
  assign result_q  = r_result;
  assign zero_q    = r_zero;
  assign hamming_q = r_hamming;

endmodule

// File: tb/tb_xor_op64.sv
// -----------------------------------------------------------------------------
// tb_xor_op64 -- self-checking bench for xor_op64 (WIDTH=64, CNT_W=7)
//
// The reference model is a plain software view of the unit: the expected
// combinational value is a ^ b, and the expected registered state is the
// last captured (a ^ b, a == b, $countones(a ^ b)) together with whether the
// previous edge saw in_valid. Inputs change on the falling edge; registered
// outputs are sampled 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_xor_op64;

  localparam int WIDTH = 64;
  localparam int CNT_W = 7;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] result;
  logic             in_valid;
  logic             out_valid;
  logic [WIDTH-1:0] result_q;
  logic             zero_q;
  logic [CNT_W-1:0] hamming_q;

  xor_op64 #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .b         (b),
    .result    (result),
    .in_valid  (in_valid),
    .out_valid (out_valid),
    .result_q  (result_q),
    .zero_q    (zero_q),
    .hamming_q (hamming_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Expected registered state.
  logic             exp_valid;
  logic [WIDTH-1:0] exp_result;
  logic             exp_zero;
  int               exp_ham;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    exp_valid  = 1'b0;
    exp_result = '0;
    exp_zero   = 1'b0;
    exp_ham    = 0;
  endtask

  task automatic check_regs(input string tag);
    check({tag, ".out_valid"}, 64'(out_valid), 64'(exp_valid));
    check({tag, ".result_q"},  result_q,       exp_result);
    check({tag, ".zero_q"},    64'(zero_q),    64'(exp_zero));
    check({tag, ".hamming_q"}, 64'(hamming_q), 64'(exp_ham));
  endtask

  // One clock cycle: apply inputs on the falling edge, check the
  // combinational result, then check the registered path after the edge.
  task automatic step(input string tag, input logic [WIDTH-1:0] va,
                      input logic [WIDTH-1:0] vb, input logic v);
    @(negedge clk);
    a = va; b = vb; in_valid = v;
    #1;
    check({tag, ".result"}, result, va ^ vb);
    @(posedge clk);
    #1;
    if (v) begin
      exp_valid  = 1'b1;
      exp_result = va ^ vb;
      exp_zero   = (va == vb);
      exp_ham    = $countones(va ^ vb);
    end else begin
      exp_valid  = 1'b0;
    end
    check_regs(tag);
  endtask

  initial begin
    logic [WIDTH-1:0] p0_a, p0_b, p1_a, p1_b;
    rst_n = 1'b0; a = '0; b = '0; in_valid = 1'b1;
    model_reset();

    // Reset state, held across edges with in_valid asserted.
    repeat (2) @(posedge clk);
    #1;
    check_regs("reset");

    // Combinational sweep while held in reset: result must not depend on it.
    in_valid = 1'b0;
    for (int i = 1; i <= 256; i++) begin
      for (int j = 1; j <= 256; j++) begin
        a = WIDTH'(i); b = WIDTH'(j);
        #5;
        check("sweep", result, WIDTH'(i ^ j));
      end
    end

    // Release between edges; nothing valid until a capture.
    @(negedge clk);
    rst_n = 1'b1;
    step("post_release", 64'h0, 64'h0, 1'b0);

    // Directed corner cases.
    step("all_ones", 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1);
    step("equal",    64'hDEAD_BEEF_0123_4567, 64'hDEAD_BEEF_0123_4567, 1'b1);
    step("msb",      64'h8000_0000_0000_0001, 64'h1, 1'b1);
    step("lsb_only", 64'h0, 64'h1, 1'b1);

    // Pulse pattern: valid on cycles 0 and 1, low on 2, then one more idle.
    p0_a = {$urandom, $urandom}; p0_b = {$urandom, $urandom};
    p1_a = {$urandom, $urandom}; p1_b = {$urandom, $urandom};
    step("pulse_c0", p0_a, p0_b, 1'b1);
    step("pulse_c1", p1_a, p1_b, 1'b1);
    step("pulse_c2", {$urandom, $urandom}, {$urandom, $urandom}, 1'b0);
    check("pulse_hold", result_q, p1_a ^ p1_b);
    step("pulse_c3", {$urandom, $urandom}, {$urandom, $urandom}, 1'b0);

    // Randomized stream with random valid density and sparse bit patterns
    // so small and large Hamming counts both occur.
    for (int k = 0; k < 400; k++) begin
      logic [WIDTH-1:0] ra, rb;
      ra = {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0:       rb = ra;
        1:       rb = ra ^ (64'h1 << $urandom_range(0, 63));
        2:       rb = ~ra;
        default: rb = {$urandom, $urandom};
      endcase
      step("rand", ra, rb, 1'($urandom_range(0, 3) != 0));
    end

    // Asynchronous reset mid-stream while out_valid is high.
    step("pre_reset", 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_regs("async_reset");
    a = 64'hA5A5_A5A5_0000_FFFF; b = 64'h5A5A_5A5A_FFFF_FFFF;
    in_valid = 1'b1;
    #1;
    check("reset_result", result, 64'hFFFF_FFFF_FFFF_0000);
    @(posedge clk);
    #1;
    check_regs("reset_held");

    // Release with in_valid low: stays invalid, then a capture works again.
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b0;
    step("release_idle", 64'h5, 64'h3, 1'b0);
    step("release_cap",  64'h5, 64'h3, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
